// File: rtl/relu_stream_arbiter.sv
// Round-robin frame arbiter that feeds N_REQ pixel streams through one shared ReLU and an output register.
// Optional RELU_ARB_PERF_EN adds stall_cycles / frames_done performance counters.

module relu_lane #(
  parameter int D_WIDTH = 8
) (
  input  logic [D_WIDTH-1:0] din,
  output logic [D_WIDTH-1:0] dout
);
  assign dout = din[D_WIDTH-1] ? '0 : din;
endmodule

module relu_stream_arbiter #(
  parameter int D_WIDTH      = 8,
  parameter int CHANNELS     = 3,
  parameter int N_REQ        = 2,
  parameter int FRAME_PIXELS = 2048,
  parameter int ID_WIDTH     = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    in_valid,
  output logic [N_REQ-1:0]                    in_ready,
  input  logic [N_REQ*D_WIDTH*CHANNELS-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [D_WIDTH*CHANNELS-1:0]         out_data,
  output logic [ID_WIDTH-1:0]                 out_id,
  output logic                                out_last,
  output logic                                busy
`ifdef RELU_ARB_PERF_EN
  ,
  output logic [31:0]                         stall_cycles,
  output logic [15:0]                         frames_done
`endif
);
  localparam int P  = D_WIDTH * CHANNELS;
  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(FRAME_PIXELS) + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                        state, state_nx;
  logic [SW-1:0]                 gnt, rr_ptr, pick;
  logic [CW-1:0]                 pix_cnt;
  logic                          found, xfer, last_pix;
  logic [N_REQ-1:0][P-1:0]       req_pix;
  logic [CHANNELS-1:0][D_WIDTH-1:0] sel_pix, relu_pix;

  assign req_pix  = in_data;
  assign sel_pix  = req_pix[gnt];
  assign last_pix = (pix_cnt == CW'(FRAME_PIXELS - 1));
  assign xfer     = (state == STREAM) && in_valid[gnt] && (!out_valid || out_ready);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    relu_lane #(.D_WIDTH(D_WIDTH)) u_lane (.din(sel_pix[c]), .dout(relu_pix[c]));
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && in_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = SW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found)            state_nx = STREAM;
      STREAM:  if (xfer && last_pix) state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (state == STREAM) in_ready[gnt] = !out_valid || out_ready;
    busy = (state == STREAM) || (out_valid && out_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      rr_ptr    <= '0;
      pix_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        gnt     <= pick;
        pix_cnt <= '0;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= relu_pix;
        out_id    <= ID_WIDTH'(gnt);
        out_last  <= last_pix;
        pix_cnt   <= pix_cnt + 1'b1;
        if (last_pix) rr_ptr <= SW'((int'(gnt) + 1) % N_REQ);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef RELU_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      frames_done  <= '0;
    end else begin
      if (state == STREAM && !xfer && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (out_valid && out_ready && out_last && frames_done != '1)
        frames_done <= frames_done + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// Randomized and directed checks of relu_stream_arbiter against a frame-level round-robin model.
// Define RELU_ARB_PERF_EN to also exercise the performance counters.

module tb_relu_stream_arbiter;
  localparam int DW = 8, CH = 3, NR = 2, FP = 4, IDW = 3, P = DW * CH;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] in_valid, in_ready;
  logic [NR*P-1:0] in_data;
  logic out_valid, out_ready, out_last, busy;
  logic [P-1:0] out_data;
  logic [IDW-1:0] out_id;
`ifdef RELU_ARB_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] frames_done;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  relu_stream_arbiter #(.D_WIDTH(DW), .CHANNELS(CH), .N_REQ(NR), .FRAME_PIXELS(FP), .ID_WIDTH(IDW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .busy(busy)
`ifdef RELU_ARB_PERF_EN
    , .stall_cycles(stall_cycles), .frames_done(frames_done)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] relu_ref(input logic [P-1:0] p);
    logic [P-1:0] r;
    r = p;
    for (int c = 0; c < CH; c++) if (p[c*DW + DW-1]) r[c*DW +: DW] = '0;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_id, out_last, busy, in_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got v=%b d=%h id=%0d l=%b busy=%b rdy=%b, want all 0",
               out_valid, out_data, out_id, out_last, busy, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, out_data, out_id, out_last, busy, in_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got v=%b d=%h busy=%b rdy=%b, want all 0", out_valid, out_data, busy, in_ready);
    end
  endtask

  task automatic test_single();
    logic [P-1:0] pix [4];
    logic [P-1:0] expv [4];
    logic x;
    int k, cyc, first;
    pix  = '{24'h7F8001, 24'h000000, 24'hFF0102, 24'h808080};
    expv = '{24'h7F0001, 24'h000000, 24'h000102, 24'h000000};
    do_reset();
    out_ready = 1'b1;
    k = 0; cyc = 0; first = -1;
    while (k < 4 && cyc < 50) begin
      @(negedge clk);
      in_valid = 2'b01; in_data[P-1:0] = pix[k];
      #1 x = in_ready[0];
      if (x && first < 0) first = cyc;
      @(posedge clk); #1;
      cyc++;
      if (x) begin
        n_cmp++;
        if (!out_valid || out_data !== expv[k] || out_id !== 3'd0 || out_last !== (k == 3)) begin
          n_bad++;
          $display("FAIL single_px%0d: got v=%b d=%h id=%0d l=%b, want v=1 d=%h id=0 l=%b",
                   k, out_valid, out_data, out_id, out_last, expv[k], (k == 3));
        end
        k++;
      end
    end
    n_cmp++;
    if (k < 4 || first != 1) begin
      n_bad++;
      $display("FAIL single_timing: accepted %0d pixels, first accept cycle %0d, want 4 and 1", k, first);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy_pending: got %b want 1", busy);
    end
    @(negedge clk) in_valid = '0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drain: got busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_random();
    logic [P-1:0] src [NR][64];
    logic [IDW+P:0] expq [$];
    logic [IDW+P:0] held;
    logic [NR-1:0] rdy, xf;
    logic stall;
    int acc [NR];
    int cyc;
    for (int r = 0; r < NR; r++) begin
      acc[r] = 0;
      for (int i = 0; i < 64; i++) src[r][i] = P'($urandom);
    end
    // With every idle requester asserting valid, grants must strictly alternate.
    for (int f = 0; f < 12; f++)
      for (int k = 0; k < FP; k++)
        expq.push_back({(k == FP-1), IDW'(f % NR), relu_ref(src[f % NR][(f / NR) * FP + k])});
    do_reset();
    cyc = 0;
    while (expq.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      out_ready = ($urandom % 10) < 7;
      for (int r = 0; r < NR; r++) begin
        in_valid[r] = (acc[r] % FP != 0) ? (($urandom % 10) < 8) : 1'b1;
        in_data[r*P +: P] = src[r][acc[r] & 63];
      end
      #1;
      rdy = in_ready;
      n_cmp++;
      if (rdy == '1) begin
        n_bad++;
        $display("FAIL rand_onehot: in_ready=%b at cycle %0d", rdy, cyc);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({out_last, out_id, out_data} !== expq[0]) begin
          n_bad++;
          $display("FAIL rand_out: got l=%b id=%0d d=%h, want l=%b id=%0d d=%h",
                   out_last, out_id, out_data, expq[0][IDW+P], expq[0][IDW+P-1:P], expq[0][P-1:0]);
        end
        void'(expq.pop_front());
      end
      stall = out_valid && !out_ready;
      held  = {out_last, out_id, out_data};
      xf    = in_valid & rdy;
      @(posedge clk); #1;
      cyc++;
      for (int r = 0; r < NR; r++) if (xf[r]) acc[r]++;
      if (stall) begin
        n_cmp++;
        if (!out_valid || {out_last, out_id, out_data} !== held) begin
          n_bad++;
          $display("FAIL rand_hold: got v=%b {l,id,d}=%h, want v=1 %h", out_valid, {out_last, out_id, out_data}, held);
        end
      end
    end
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL rand_timeout: %0d outputs outstanding, want 0", expq.size());
    end
    @(negedge clk) in_valid = '0;
  endtask

  task automatic test_midreset();
    logic [NR-1:0] xf;
    int total, cyc, n, bad_id;
    logic first_ok;
    do_reset();
    out_ready = 1'b1; in_valid = '1; in_data = {24'h0A0B0C, 24'h010203};
    total = 0; cyc = 0;
    // One full frame from req0, then two pixels of req1's frame.
    while (total < FP + 2 && cyc < 100) begin
      @(negedge clk); #1 xf = in_valid & in_ready;
      @(posedge clk); #1;
      cyc++;
      for (int r = 0; r < NR; r++) if (xf[r]) total++;
    end
    @(negedge clk); #2 reset = 1'b1; #1;
    n_cmp++;
    if ({out_valid, out_data, out_id, out_last, busy, in_ready} !== '0) begin
      n_bad++;
      $display("FAIL midreset_async: got v=%b d=%h id=%0d l=%b busy=%b rdy=%b, want all 0",
               out_valid, out_data, out_id, out_last, busy, in_ready);
    end
    @(negedge clk) reset = 1'b0;
    n = 0; cyc = 0; bad_id = 0; first_ok = 1'b0;
    while (cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (out_valid && out_ready) begin
        if (n == 0) first_ok = (out_id == 3'd0);
        if (out_id != 3'd0) bad_id++;
        n++;
        if (out_last) break;
      end
      @(posedge clk);
    end
    n_cmp++;
    if (!first_ok || bad_id != 0 || n != FP) begin
      n_bad++;
      $display("FAIL midreset_restart: first_id0=%b bad_ids=%0d frame_len=%0d, want 1 0 %0d", first_ok, bad_id, n, FP);
    end
    @(negedge clk) in_valid = '0;
  endtask

`ifdef RELU_ARB_PERF_EN
  task automatic test_perf();
    logic x;
    logic [2:0] bubbled;
    int acc, cyc, bi;
    do_reset();
    out_ready = 1'b1; in_data = {24'h0, 24'h123456};
    acc = 0; cyc = 0; bubbled = '0;
    while (acc < 2*FP && cyc < 200) begin
      @(negedge clk);
      bi = (acc == 1) ? 0 : (acc == 2) ? 1 : (acc == 5) ? 2 : -1;
      if (bi >= 0 && !bubbled[bi]) begin
        in_valid = 2'b00; bubbled[bi] = 1'b1;
      end else in_valid = 2'b01;
      #1 x = in_valid[0] & in_ready[0];
      @(posedge clk); #1;
      cyc++;
      if (x) acc++;
    end
    @(negedge clk) in_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (frames_done !== 16'd2 || stall_cycles !== 32'd3) begin
      n_bad++;
      $display("FAIL perf_counters: got frames_done=%0d stall_cycles=%0d, want 2 3", frames_done, stall_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random();
    test_midreset();
`ifdef RELU_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
